// File: rtl/moka_rv32i_mem_pkg.sv
// Shared types and helpers for the rv32i data-memory arbiter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package moka_rv32i_mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } arb_state_t;

  // Port index of a grant: 0 = core load/store, 1 = loader/debug.
  typedef logic grant_t;

  // Word accesses only; any nonzero byte offset is a misaligned request.
  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/moka_rv32i_rr_arb2.sv
// Two-way combinational arbiter: round-robin (mode=0) or port-0 fixed priority (mode=1).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is consumed.
// Ports: req[1:0] requests, last_grant previous winner, mode select;
//        gnt[1:0] one-hot or zero, gnt_idx index of the winner (0 when none).
module moka_rv32i_rr_arb2
  import moka_rv32i_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       mode,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  always_comb begin
    gnt     = 2'b00;
    gnt_idx = 1'b0;
    case (req)
      2'b01: begin
        gnt     = 2'b01;
        gnt_idx = 1'b0;
      end
      2'b10: begin
        gnt     = 2'b10;
        gnt_idx = 1'b1;
      end
      2'b11: begin
        // On a tie the port that did not win last time goes first,
        // unless fixed priority pins the win to port 0.
        if (mode || (last_grant == 1'b1)) begin
          gnt     = 2'b01;
          gnt_idx = 1'b0;
        end else begin
          gnt     = 2'b10;
          gnt_idx = 1'b1;
        end
      end
      default: begin
        gnt     = 2'b00;
        gnt_idx = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/moka_rv32i_mem_arbiter.sv
// Shares one single-port synchronous data memory between the core (m0) and loader (m1).
// Latency: accept -> rsp_valid is RD_LAT+1 cycles (aligned) or 1 cycle (misaligned).
// Backpressure: one transaction in flight; req_ready only in IDLE and only to the winner.
// Ports: clk, rstn; m0_*/m1_* request (valid/ready/addr/wdata/we) and response
//        (valid/rdata/err); en/address/wr_data/mem_we/rd_data drive the memory.
module moka_rv32i_mem_arbiter
  import moka_rv32i_mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RD_LAT   = 1,
  parameter int ARB_MODE = 0
) (
  input  logic              clk,
  input  logic              rstn,

  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic [DATA_W-1:0] m0_req_wdata,
  input  logic              m0_req_we,
  output logic              m0_rsp_valid,
  output logic [DATA_W-1:0] m0_rsp_rdata,
  output logic              m0_rsp_err,

  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic [DATA_W-1:0] m1_req_wdata,
  input  logic              m1_req_we,
  output logic              m1_rsp_valid,
  output logic [DATA_W-1:0] m1_rsp_rdata,
  output logic              m1_rsp_err,

  output logic              en,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] wr_data,
  output logic              mem_we,
  input  logic [DATA_W-1:0] rd_data
);

  if ((RD_LAT < 1) || (RD_LAT > 4)) begin : g_bad_rd_lat
    $fatal(1, "moka_rv32i_mem_arbiter: RD_LAT=%0d outside 1..4", RD_LAT);
  end

  // WAIT lasts RD_LAT-1 cycles; the counter is loaded with that minus one.
  localparam int   WAIT_LOAD  = (RD_LAT > 2) ? (RD_LAT - 2) : 0;
  localparam logic MODE_FIXED = (ARB_MODE != 0);

  arb_state_t        state_q;
  arb_state_t        state_nxt;
  grant_t            last_grant_q;
  grant_t            grant_q;
  logic              we_q;
  logic              err_q;
  logic [1:0]        wait_cnt;
  logic [DATA_W-1:0] rdata_q;

  logic [1:0]        gnt;
  logic              gnt_idx;
  logic              accept;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_we;
  logic              acc_aligned;

  moka_rv32i_rr_arb2 u_arb (
    .req        ({m1_req_valid, m0_req_valid}),
    .last_grant (last_grant_q),
    .mode       (MODE_FIXED),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  // A grant implies the port is valid, so grant in IDLE is the handshake.
  assign accept      = (state_q == IDLE) && (gnt != 2'b00);
  assign acc_addr    = gnt_idx ? m1_req_addr  : m0_req_addr;
  assign acc_wdata   = gnt_idx ? m1_req_wdata : m0_req_wdata;
  assign acc_we      = gnt_idx ? m1_req_we    : m0_req_we;
  assign acc_aligned = is_aligned(acc_addr[1:0]);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_nxt = acc_aligned ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        if (RD_LAT > 1) begin
          state_nxt = WAIT;
        end else begin
          state_nxt = RESP;
        end
      end
      WAIT: begin
        if (wait_cnt == 2'd0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Command capture, latency counter and read-data sampling.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      wait_cnt     <= 2'd0;
      rdata_q      <= '0;
      address      <= '0;
      wr_data      <= '0;
    end else begin
      if (accept) begin
        last_grant_q <= gnt_idx;
        grant_q      <= gnt_idx;
        we_q         <= acc_we;
        err_q        <= !acc_aligned;
        // The memory bus only moves for accesses that will really strobe it.
        if (acc_aligned) begin
          address <= acc_addr;
          wr_data <= acc_wdata;
        end
      end
      if (state_q == ACCESS) begin
        wait_cnt <= 2'(WAIT_LOAD);
      end else if ((state_q == WAIT) && (wait_cnt != 2'd0)) begin
        wait_cnt <= wait_cnt - 2'd1;
      end
      // The edge that enters RESP is the RD_LAT-th edge after ACCESS began.
      if (((state_q == ACCESS) || (state_q == WAIT)) && (state_nxt == RESP) && !we_q) begin
        rdata_q <= rd_data;
      end
    end
  end

  // Output decode.
  always_comb begin
    en           = 1'b0;
    mem_we       = 1'b0;
    m0_req_ready = 1'b0;
    m1_req_ready = 1'b0;
    m0_rsp_valid = 1'b0;
    m0_rsp_err   = 1'b0;
    m0_rsp_rdata = '0;
    m1_rsp_valid = 1'b0;
    m1_rsp_err   = 1'b0;
    m1_rsp_rdata = '0;
    case (state_q)
      IDLE: begin
        m0_req_ready = gnt[0];
        m1_req_ready = gnt[1];
      end
      ACCESS: begin
        en     = 1'b1;
        mem_we = we_q;
      end
      RESP: begin
        if (grant_q == 1'b0) begin
          m0_rsp_valid = 1'b1;
          m0_rsp_err   = err_q;
          m0_rsp_rdata = (we_q || err_q) ? '0 : rdata_q;
        end else begin
          m1_rsp_valid = 1'b1;
          m1_rsp_err   = err_q;
          m1_rsp_rdata = (we_q || err_q) ? '0 : rdata_q;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_moka_rv32i_mem_arbiter.sv
// Bench for the data-memory arbiter: instance a is RD_LAT=1 round-robin,
// instance b is RD_LAT=3 fixed priority. A transaction-level model predicts
// every output each cycle; directed tests pin latencies and data with literals.
module tb_moka_rv32i_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn   [2];
  logic        req_v  [2][2];
  logic        req_r  [2][2];
  logic [31:0] req_a  [2][2];
  logic [31:0] req_d  [2][2];
  logic        req_we [2][2];
  logic        rsp_v  [2][2];
  logic [31:0] rsp_d  [2][2];
  logic        rsp_e  [2][2];
  logic        en     [2];
  logic        mwe    [2];
  logic [31:0] maddr  [2];
  logic [31:0] mwd    [2];
  logic [31:0] mrd    [2];

  moka_rv32i_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .ARB_MODE(0)) dut_a (
    .clk(clk), .rstn(rstn[0]),
    .m0_req_valid(req_v[0][0]), .m0_req_ready(req_r[0][0]), .m0_req_addr(req_a[0][0]),
    .m0_req_wdata(req_d[0][0]), .m0_req_we(req_we[0][0]), .m0_rsp_valid(rsp_v[0][0]),
    .m0_rsp_rdata(rsp_d[0][0]), .m0_rsp_err(rsp_e[0][0]),
    .m1_req_valid(req_v[0][1]), .m1_req_ready(req_r[0][1]), .m1_req_addr(req_a[0][1]),
    .m1_req_wdata(req_d[0][1]), .m1_req_we(req_we[0][1]), .m1_rsp_valid(rsp_v[0][1]),
    .m1_rsp_rdata(rsp_d[0][1]), .m1_rsp_err(rsp_e[0][1]),
    .en(en[0]), .address(maddr[0]), .wr_data(mwd[0]), .mem_we(mwe[0]), .rd_data(mrd[0])
  );

  moka_rv32i_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3), .ARB_MODE(1)) dut_b (
    .clk(clk), .rstn(rstn[1]),
    .m0_req_valid(req_v[1][0]), .m0_req_ready(req_r[1][0]), .m0_req_addr(req_a[1][0]),
    .m0_req_wdata(req_d[1][0]), .m0_req_we(req_we[1][0]), .m0_rsp_valid(rsp_v[1][0]),
    .m0_rsp_rdata(rsp_d[1][0]), .m0_rsp_err(rsp_e[1][0]),
    .m1_req_valid(req_v[1][1]), .m1_req_ready(req_r[1][1]), .m1_req_addr(req_a[1][1]),
    .m1_req_wdata(req_d[1][1]), .m1_req_we(req_we[1][1]), .m1_rsp_valid(rsp_v[1][1]),
    .m1_rsp_rdata(rsp_d[1][1]), .m1_rsp_err(rsp_e[1][1]),
    .en(en[1]), .address(maddr[1]), .wr_data(mwd[1]), .mem_we(mwe[1]), .rd_data(mrd[1])
  );

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic fixed_prio(input int i);
    return (i == 1);
  endfunction

  function automatic logic [31:0] init_word(input int i, input int w);
    if ((i == 0) && (w == 4))  return 32'hDEAD_BEEF;
    if ((i == 1) && (w == 16)) return 32'h1234_5678;
    return 32'hA500_0000 | 32'(i << 16) | 32'(w);
  endfunction

  // ---------------- memory model: combinational read delayed by RD_LAT-1 edges
  logic [31:0] wmem   [2][64];
  bit          wmem_v [2][64];
  logic [31:0] rd_comb [2];
  logic [31:0] pipe0   [2];
  logic [31:0] pipe1   [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rd_comb[i] = 32'hBADB_AD00;
      if (en[i] && !mwe[i]) begin
        rd_comb[i] = wmem_v[i][maddr[i][7:2]] ? wmem[i][maddr[i][7:2]]
                                               : init_word(i, int'(maddr[i][7:2]));
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      pipe0[i] <= rd_comb[i];
      pipe1[i] <= pipe0[i];
      if (en[i] && mwe[i]) begin
        wmem[i][maddr[i][7:2]]   <= mwd[i];
        wmem_v[i][maddr[i][7:2]] <= 1'b1;
      end
    end
  end

  assign mrd[0] = rd_comb[0];
  assign mrd[1] = pipe1[1];

  // ---------------- bookkeeping
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- transaction-level model
  int          m_busy [2];
  int          m_acc  [2];
  int          m_rsp  [2];
  logic        m_lg   [2];
  logic [31:0] m_la   [2];
  logic [31:0] m_lw   [2];
  int          t_port [2];
  logic [31:0] t_addr [2];
  logic [31:0] t_wd   [2];
  logic [31:0] t_rd   [2];
  logic        t_we   [2];
  logic        t_mis  [2];
  logic [31:0] shadow [2][64];
  int          en_cnt [2];
  logic [31:0] en_addr[2];
  logic [31:0] en_wd  [2];
  logic        en_we  [2];

  task automatic model_reset(input int i);
    m_busy[i] = 0;
    m_acc[i]  = -1;
    m_rsp[i]  = -1;
    m_lg[i]   = 1'b1;
    m_la[i]   = '0;
    m_lw[i]   = '0;
  endtask

  task automatic model_step(input int i);
    string tg;
    logic  exp_en;
    int    win;
    tg = (i == 0) ? "a" : "b";
    if (!rstn[i]) model_reset(i);
    win = -1;
    if (rstn[i] && (cyc >= m_busy[i])) begin
      if (req_v[i][0] && req_v[i][1]) win = (fixed_prio(i) || m_lg[i]) ? 0 : 1;
      else if (req_v[i][0]) win = 0;
      else if (req_v[i][1]) win = 1;
    end
    exp_en = (cyc == m_acc[i]);
    chk1({tg, ".en"}, en[i], exp_en);
    chk1({tg, ".mem_we"}, mwe[i], exp_en && t_we[i]);
    chk({tg, ".address"}, maddr[i], exp_en ? t_addr[i] : m_la[i]);
    chk({tg, ".wr_data"}, mwd[i], exp_en ? t_wd[i] : m_lw[i]);
    for (int p = 0; p < 2; p++) begin
      logic rv;
      rv = (cyc == m_rsp[i]) && (t_port[i] == p);
      chk1($sformatf("%s.m%0d_req_ready", tg, p), req_r[i][p], win == p);
      chk1($sformatf("%s.m%0d_rsp_valid", tg, p), rsp_v[i][p], rv);
      chk1($sformatf("%s.m%0d_rsp_err", tg, p), rsp_e[i][p], rv && t_mis[i]);
      chk($sformatf("%s.m%0d_rsp_rdata", tg, p), rsp_d[i][p], rv ? t_rd[i] : 32'h0);
    end
    if (exp_en) begin
      m_la[i] = t_addr[i];
      m_lw[i] = t_wd[i];
    end
    if (en[i]) begin
      en_cnt[i]++;
      en_addr[i] = maddr[i];
      en_wd[i]   = mwd[i];
      en_we[i]   = mwe[i];
    end
    if (win >= 0) begin
      t_port[i] = win;
      t_addr[i] = req_a[i][win];
      t_wd[i]   = req_d[i][win];
      t_we[i]   = req_we[i][win];
      t_mis[i]  = (t_addr[i][1:0] != 2'b00);
      if (t_mis[i]) begin
        m_acc[i] = -1;
        m_rsp[i] = cyc + 1;
      end else begin
        m_acc[i] = cyc + 1;
        m_rsp[i] = cyc + 1 + lat(i);
      end
      m_busy[i] = m_rsp[i] + 1;
      m_lg[i]   = win[0];
      t_rd[i]   = (t_we[i] || t_mis[i]) ? 32'h0 : shadow[i][t_addr[i][7:2]];
      if (t_we[i] && !t_mis[i]) shadow[i][t_addr[i][7:2]] = t_wd[i];
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 64; w++) shadow[i][w] = init_word(i, w);
      model_reset(i);
      en_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- directed stimulus helpers
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int i, input int p, input logic [31:0] a, input logic [31:0] d,
                       input logic we, output int acc_c);
    req_v[i][p]  = 1'b1;
    req_a[i][p]  = a;
    req_d[i][p]  = d;
    req_we[i][p] = we;
    acc_c = -1;
    for (int k = 0; k < 40 && acc_c < 0; k++) begin
      @(negedge clk);
      if (req_r[i][p]) acc_c = cyc;
    end
    chk1("issue.accepted", acc_c >= 0, 1'b1);
    tick;
    // Scramble the payload after accept; the captured command must not change.
    req_v[i][p]  = 1'b0;
    req_a[i][p]  = 32'hFFFF_FFF0;
    req_d[i][p]  = 32'h0BAD_0BAD;
    req_we[i][p] = !we;
  endtask

  task automatic wait_rsp(input int i, input int p, output int rc, output logic [31:0] d,
                          output logic e);
    rc = -1;
    d  = '0;
    e  = 1'b0;
    for (int k = 0; k < 40 && rc < 0; k++) begin
      @(negedge clk);
      if (rsp_v[i][p]) begin
        rc = cyc;
        d  = rsp_d[i][p];
        e  = rsp_e[i][p];
      end
    end
    chk1("wait_rsp.seen", rc >= 0, 1'b1);
  endtask

  task automatic contend(input int i, input int nreq, output logic [3:0] ord, output int n,
                         output int both, output int r1);
    req_v[i][0] = 1'b1; req_a[i][0] = 32'h0; req_d[i][0] = 32'h0; req_we[i][0] = 1'b0;
    req_v[i][1] = 1'b1; req_a[i][1] = 32'h4; req_d[i][1] = 32'h0; req_we[i][1] = 1'b0;
    ord = '0; n = 0; both = 0; r1 = 0;
    for (int k = 0; k < 80 && n < nreq; k++) begin
      @(negedge clk);
      if (req_r[i][0] && req_r[i][1]) both++;
      if (req_r[i][1]) r1++;
      if (req_r[i][0]) begin
        ord[n] = 1'b0;
        n++;
      end else if (req_r[i][1]) begin
        ord[n] = 1'b1;
        n++;
      end
    end
    tick;
    req_v[i][0] = 1'b0;
    req_v[i][1] = 1'b0;
    repeat (8) tick;
  endtask

  task automatic rst_outs(input int i);
    chk1("rst.en", en[i], 1'b0);
    chk1("rst.mem_we", mwe[i], 1'b0);
    chk("rst.address", maddr[i], 32'h0);
    chk("rst.wr_data", mwd[i], 32'h0);
    for (int p = 0; p < 2; p++) begin
      chk1("rst.req_ready", req_r[i][p], 1'b0);
      chk1("rst.rsp_valid", rsp_v[i][p], 1'b0);
      chk1("rst.rsp_err", rsp_e[i][p], 1'b0);
      chk("rst.rsp_rdata", rsp_d[i][p], 32'h0);
    end
  endtask

  // ---------------- directed tests
  initial begin
    int          acc, rc, e0, n, both, r1;
    logic [31:0] d;
    logic        e;
    logic [3:0]  ord;

    for (int i = 0; i < 2; i++) begin
      rstn[i] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        req_v[i][p] = 1'b0; req_a[i][p] = '0; req_d[i][p] = '0; req_we[i][p] = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    rst_outs(0);
    rst_outs(1);
    tick;
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;
    tick;

    // Single read, RD_LAT=1.
    e0 = en_cnt[0];
    issue(0, 0, 32'h10, 32'h0, 1'b0, acc);
    wait_rsp(0, 0, rc, d, e);
    chk("t1.latency", 32'(rc - acc), 32'd2);
    chk("t1.rdata", d, 32'hDEAD_BEEF);
    chk1("t1.err", e, 1'b0);
    tick;
    chk("t1.en_pulses", 32'(en_cnt[0] - e0), 32'd1);
    chk("t1.en_addr", en_addr[0], 32'h10);
    chk1("t1.en_we", en_we[0], 1'b0);

    // Write then read from port 1.
    e0 = en_cnt[0];
    issue(0, 1, 32'h20, 32'hCAFE_0001, 1'b1, acc);
    wait_rsp(0, 1, rc, d, e);
    chk("t2.wr_rdata", d, 32'h0);
    chk("t2.wr_latency", 32'(rc - acc), 32'd2);
    tick;
    chk("t2.en_pulses", 32'(en_cnt[0] - e0), 32'd1);
    chk1("t2.en_we", en_we[0], 1'b1);
    chk("t2.en_wdata", en_wd[0], 32'hCAFE_0001);
    issue(0, 1, 32'h20, 32'h0, 1'b0, acc);
    wait_rsp(0, 1, rc, d, e);
    chk("t2.rd_rdata", d, 32'hCAFE_0001);
    tick;

    // Round-robin contention.
    contend(0, 4, ord, n, both, r1);
    chk("t3.grants", 32'(n), 32'd4);
    chk("t3.order", 32'(ord), 32'b1010);
    chk("t3.two_ready", 32'(both), 32'd0);

    // Misaligned read.
    e0 = en_cnt[0];
    issue(0, 0, 32'h13, 32'h0, 1'b0, acc);
    wait_rsp(0, 0, rc, d, e);
    chk("t4.latency", 32'(rc - acc), 32'd1);
    chk1("t4.err", e, 1'b1);
    chk("t4.rdata", d, 32'h0);
    tick;
    chk("t4.en_pulses", 32'(en_cnt[0] - e0), 32'd0);

    // Reset during ACCESS after an m0 win; the next tie must still go to m0.
    issue(0, 0, 32'h10, 32'h0, 1'b0, acc);
    rstn[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      rst_outs(0);
    end
    tick;
    rstn[0] = 1'b1;
    contend(0, 1, ord, n, both, r1);
    chk("t5.first_tie", 32'(ord[0]), 32'd0);

    // RD_LAT=3 read.
    issue(1, 0, 32'h40, 32'h0, 1'b0, acc);
    wait_rsp(1, 0, rc, d, e);
    chk("t6.latency", 32'(rc - acc), 32'd4);
    chk("t6.rdata", d, 32'h1234_5678);
    tick;

    // Fixed-priority contention.
    contend(1, 4, ord, n, both, r1);
    chk("t7.grants", 32'(n), 32'd4);
    chk("t7.order", 32'(ord), 32'b0000);
    chk("t7.m1_ready", 32'(r1), 32'd0);

    // Reset during WAIT.
    issue(1, 0, 32'h44, 32'h0, 1'b0, acc);
    tick;
    rstn[1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      rst_outs(1);
    end
    tick;
    rstn[1] = 1'b1;
    contend(1, 1, ord, n, both, r1);
    chk("t8.first_tie", 32'(ord[0]), 32'd0);

    repeat (4) tick;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/moka_rv32i_mem_arbiter.md
Name: moka_rv32i_mem_arbiter

Overview:
- Shares one single-port synchronous data memory between two requesters: port 0 is the core load/store port, port 1 is the program loader/debug port.
- Arbitrates, registers the winning command, drives the memory bus (en, address, wr_data, mem_we, rd_data), waits the read latency, then returns a one-cycle response to the winner.
- Sits between the rv32i single-cycle core/loader and the data memory model.
- Only one transaction is outstanding at a time.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RD_LAT, 1, memory read latency in cycles after the access cycle. Legal range 1..4.
- ARB_MODE, 0, arbitration mode. 0 = round-robin, 1 = fixed priority (port 0 wins).

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- m0_req_valid  input  1  port 0 request.
- m0_req_ready  output  1  port 0 request accepted this cycle.
- m0_req_addr  input  ADDR_W  port 0 byte address.
- m0_req_wdata  input  DATA_W  port 0 write data.
- m0_req_we  input  1  port 0 write enable.
- m0_rsp_valid  output  1  port 0 response pulse.
- m0_rsp_rdata  output  DATA_W  port 0 read data.
- m0_rsp_err  output  1  port 0 misaligned-access error.
- m1_*  same seven signals for port 1.
- en  output  1  memory access strobe.
- address  output  ADDR_W  memory address.
- wr_data  output  DATA_W  memory write data.
- mem_we  output  1  memory write enable.
- rd_data  input  DATA_W  memory read data.

Behaviour:
- Reset (async, rstn=0): state=IDLE; en, mem_we, all req_ready, rsp_valid, rsp_err = 0; address, wr_data, all rsp_rdata = 0; last_grant = 1, so port 0 wins the first tie.
- States:
  - IDLE -> ACCESS when a request is accepted and it is aligned.
  - IDLE -> RESP when an accepted request is misaligned.
  - ACCESS -> WAIT if RD_LAT > 1; otherwise ACCESS -> RESP.
  - WAIT -> RESP after RD_LAT-1 cycles, tracked by a down-counter.
  - RESP -> IDLE.
- req_ready is combinational and is asserted only in IDLE, only to the winner. At most one req_ready is high in any cycle.
- Accept condition is valid && ready at a rising edge. At accept, addr, wdata, we and the grant index are captured into registers.
- Arbitration:
  - Round-robin (ARB_MODE=0): when both ports are valid, the port not equal to last_grant wins. last_grant is updated at accept.
  - Fixed priority (ARB_MODE=1): port 0 always wins.
  - A single valid port wins regardless of mode.
- ACCESS (exactly one cycle):
  - en=1, address=captured addr, wr_data=captured wdata, mem_we=captured we.
  - In every other state en=0 and mem_we=0; address and wr_data hold their last values.
- Read data is sampled from rd_data on the RD_LAT-th clock edge after the ACCESS edge, then presented in RESP.
- RESP (exactly one cycle):
  - rsp_valid=1 on the granted port only.
  - rsp_rdata = sampled data for a read, 0 for a write.
  - rsp_err=0.
  - The other port's rsp_* outputs are 0.
- Misaligned access (addr[1:0] != 0): the memory is never strobed (en stays 0). RESP gives rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Latency from accept edge to rsp_valid:
  - aligned access: RD_LAT+1 cycles.
  - misaligned access: 1 cycle.
- Throughput: next accept no earlier than the cycle after RESP. Aligned access occupies RD_LAT+2 cycles per transaction.
- A requester must hold valid and its payload stable until ready. Payload changes after accept are ignored.
- A request that deasserts valid before ready is dropped silently; no response is produced.
- Reset asserted mid-transaction: the transaction is abandoned with no response, and all outputs return to their reset values immediately.
- RD_LAT outside 1..4: elaboration-time assertion failure.

Decomposition:
- Package moka_rv32i_mem_pkg holds:
  - ADDR_W and DATA_W defaults;
  - typedef enum arb_state_t {IDLE, ACCESS, WAIT, RESP};
  - typedef logic grant_t (0/1);
  - function is_aligned(addr).
- Sub-module moka_rv32i_rr_arb2: pure 2-way arbiter.
  - Inputs: req[1:0], last_grant, mode.
  - Outputs: gnt[1:0] one-hot or zero, gnt_idx.
  - Combinational only; the FSM in the top holds last_grant.

Test Plan:
- Single read (RD_LAT=1): m0 reads 0x0000_0010, memory returns 0xDEAD_BEEF -> en=1 exactly one cycle with address=0x10 and mem_we=0; m0_rsp_valid pulses 2 cycles after accept with rdata=0xDEAD_BEEF.
- Write then read: m1 writes 0xCAFE_0001 to 0x20, then reads 0x20 -> mem_we=1 for one cycle with wr_data=0xCAFE_0001; write response has rdata=0; read response returns 0xCAFE_0001.
- Contention, round-robin: m0 and m1 both valid continuously for 4 transactions -> grant order m0, m1, m0, m1; never two ready signals in the same cycle.
- Contention, ARB_MODE=1: same stimulus -> m0 served every time while m1 stays unready.
- Misaligned access: m0 reads 0x0000_0013 -> en never asserted; 1 cycle after accept, rsp_valid=1, rsp_err=1, rdata=0.
- RD_LAT=3 with reset: read of 0x40 -> rsp_valid 4 cycles after accept. Separately, assert rstn=0 during WAIT -> no rsp_valid, all outputs 0, state IDLE; the next tied request goes to m0.
